// File: rtl/note_seq_pkg.sv
// note_seq_pkg: shared types and constants for the song note sequencer.
// Holds the FSM state enum, the song-table entry layout, waveform codes
// and the end-of-song marker used by note_sequencer and song_rom.
package note_seq_pkg;

    localparam int FREQ_W = 14;
    localparam int WAVE_W = 2;
    localparam int DUR_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_GAP,
        ST_DONE
    } state_t;

    typedef enum logic [WAVE_W-1:0] {
        WAVE_SINE     = 2'd0,
        WAVE_SQUARE   = 2'd1,
        WAVE_TRIANGLE = 2'd2,
        WAVE_RSVD     = 2'd3
    } wave_t;

    typedef struct packed {
        logic [FREQ_W-1:0] freq;
        logic [WAVE_W-1:0] wave;
        logic [DUR_W-1:0]  dur;
    } song_entry_t;

    // A duration of zero terminates the song.
    localparam logic [DUR_W-1:0]  END_MARKER   = '0;
    localparam logic [FREQ_W-1:0] FREQ_SILENCE = '0;

    // The reserved waveform code is played as a sine.
    function automatic logic [WAVE_W-1:0] sanitize_wave(input logic [WAVE_W-1:0] wave);
        return (wave == 2'(WAVE_RSVD)) ? 2'(WAVE_SINE) : wave;
    endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// note_sequencer_if: control and tone-output bundle of the note sequencer.
// The master side (song-mode controller) drives start/stop/loop_en; the
// slave side (note_sequencer) drives the tone-generator selections.
interface note_sequencer_if #(
    parameter int IDX_W = 5
);
    logic             start;
    logic             stop;
    logic             loop_en;
    logic [13:0]      frequency;
    logic [1:0]       waveform;
    logic             note_strobe;
    logic             playing;
    logic             done;
    logic [IDX_W-1:0] note_index;

    modport master (
        output start, stop, loop_en,
        input  frequency, waveform, note_strobe, playing, done, note_index
    );

    modport slave (
        input  start, stop, loop_en,
        output frequency, waveform, note_strobe, playing, done, note_index
    );
endinterface

// File: rtl/song_rom.sv
// song_rom: combinational song table indexed by note index.
// Contents are produced by the song-table generator script; this image holds
// the short reference tune: 440 Hz sine (3 ticks), rest (2 ticks),
// 880 Hz triangle (1 tick), end marker. Unlisted entries are end markers.
module song_rom
    import note_seq_pkg::*;
#(
    parameter int IDX_W = 5
) (
    input  logic [IDX_W-1:0] i_index,
    output song_entry_t      o_entry
);

    // Table lookup for the requested entry.
    always_comb begin
        // NOTE: o_entry gets a default before the case so every index drives it and no latch is inferred.
        o_entry = '{freq: FREQ_SILENCE, wave: 2'(WAVE_SINE), dur: END_MARKER};
        case (i_index)
            IDX_W'(0): o_entry = '{freq: 14'd440, wave: 2'(WAVE_SINE),     dur: 8'd3};
            IDX_W'(1): o_entry = '{freq: 14'd0,   wave: 2'(WAVE_SINE),     dur: 8'd2};
            IDX_W'(2): o_entry = '{freq: 14'd880, wave: 2'(WAVE_TRIANGLE), dur: 8'd1};
            default:   o_entry = '{freq: FREQ_SILENCE, wave: 2'(WAVE_SINE), dur: END_MARKER};
        endcase
    end

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: steps through song_rom at TICK_CYCLES clocks per duration
// tick, driving frequency/waveform to the tone generators.
// Optional feature: define NOTE_GAP_EN to silence the last GAP_TICKS ticks
// of every note longer than GAP_TICKS; without it notes are legato.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int SONG_LEN    = 32,
    parameter int TICK_CYCLES = 500,
    parameter int GAP_TICKS   = 2
) (
    input  logic            CLK_32KHz,
    input  logic            reset_n,
    note_sequencer_if.slave bus
);

    localparam int IDX_W = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
    localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SONG_LEN - 1);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_CYCLES - 1);
    localparam logic [DUR_W-1:0] GAP_LEVEL = DUR_W'(GAP_TICKS);
`ifdef NOTE_GAP_EN
    localparam bit GAP_ON = (GAP_TICKS > 0);
`else
    localparam bit GAP_ON = 1'b0;
`endif

    state_t             r_state,    w_state_next;
    logic [IDX_W-1:0]   r_index,    w_index_next;
    logic               r_past_end, w_past_end_next;
    logic [PRE_W-1:0]   r_pre,      w_pre_next;
    logic [DUR_W-1:0]   r_ticks,    w_ticks_next;
    logic [FREQ_W-1:0]  r_freq,     w_freq_next;
    logic [WAVE_W-1:0]  r_wave,     w_wave_next;
    logic               r_strobe,   w_strobe_next;
    logic               w_wrap;
    logic [DUR_W-1:0]   w_ticks_dec;
    song_entry_t        w_entry;

    song_rom #(.IDX_W(IDX_W)) u_song_rom (
        .i_index (r_index),
        .o_entry (w_entry)
    );

    assign w_wrap      = (r_pre == PRE_LAST);
    assign w_ticks_dec = r_ticks - 8'd1;

    // State register.
    always_ff @(posedge CLK_32KHz or negedge reset_n) begin
        // NOTE: clocked state uses non-blocking assignments so all registers update together at the edge.
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, index, prescaler, tick and tone selection logic.
    always_comb begin
        w_state_next    = r_state;
        w_index_next    = r_index;
        w_past_end_next = r_past_end;
        w_pre_next      = r_pre;
        w_ticks_next    = r_ticks;
        w_freq_next     = r_freq;
        w_wave_next     = r_wave;
        w_strobe_next   = 1'b0;

        if (bus.stop) begin
            // Abort from any state; stop beats a simultaneous start.
            w_state_next    = ST_IDLE;
            w_index_next    = '0;
            w_past_end_next = 1'b0;
            w_freq_next     = FREQ_SILENCE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_freq_next = FREQ_SILENCE;
                    if (bus.start) begin
                        w_state_next    = ST_LOAD;
                        w_index_next    = '0;
                        w_past_end_next = 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (!r_past_end && (w_entry.dur != END_MARKER)) begin
                        w_state_next  = ST_PLAY;
                        w_freq_next   = w_entry.freq;
                        w_wave_next   = sanitize_wave(w_entry.wave);
                        w_ticks_next  = w_entry.dur;
                        w_pre_next    = '0;
                        w_strobe_next = 1'b1;
                    end else if (bus.loop_en) begin
                        // Loop seam: one extra LOAD to fetch entry 0.
                        w_state_next    = ST_LOAD;
                        w_index_next    = '0;
                        w_past_end_next = 1'b0;
                    end else begin
                        w_state_next = ST_DONE;
                        w_freq_next  = FREQ_SILENCE;
                    end
                end
                ST_PLAY, ST_GAP: begin
                    w_pre_next = w_wrap ? '0 : r_pre + 1'b1;
                    if (w_wrap) begin
                        w_ticks_next = w_ticks_dec;
                        if (w_ticks_dec == '0) begin
                            w_state_next = ST_LOAD;
                            // The last table slot marks past-end instead of wrapping the index.
                            if (r_index == LAST_IDX) begin
                                w_past_end_next = 1'b1;
                            end else begin
                                w_index_next = r_index + 1'b1;
                            end
                        end else if (GAP_ON && (r_state == ST_PLAY) && (w_ticks_dec == GAP_LEVEL)) begin
                            // Only notes longer than GAP_TICKS ever count down to this level.
                            w_state_next = ST_GAP;
                            w_freq_next  = FREQ_SILENCE;
                        end
                    end
                end
                ST_DONE: begin
                    w_state_next = ST_IDLE;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Datapath registers: index, prescaler, ticks and tone selection.
    always_ff @(posedge CLK_32KHz or negedge reset_n) begin
        if (!reset_n) begin
            r_index    <= '0;
            r_past_end <= 1'b0;
            r_pre      <= '0;
            r_ticks    <= '0;
            r_freq     <= FREQ_SILENCE;
            r_wave     <= 2'(WAVE_SINE);
            r_strobe   <= 1'b0;
        end else begin
            r_index    <= w_index_next;
            r_past_end <= w_past_end_next;
            r_pre      <= w_pre_next;
            r_ticks    <= w_ticks_next;
            r_freq     <= w_freq_next;
            r_wave     <= w_wave_next;
            r_strobe   <= w_strobe_next;
        end
    end

    assign bus.frequency   = r_freq;
    assign bus.waveform    = r_wave;
    assign bus.note_strobe = r_strobe;
    assign bus.note_index  = r_index;
    assign bus.playing     = (r_state == ST_LOAD) || (r_state == ST_PLAY) || (r_state == ST_GAP);
    assign bus.done        = (r_state == ST_DONE);

endmodule
